// File: rtl/minimig_autoconfig_chain.sv
// rtl/minimig_autoconfig_chain.sv - Amiga autoconfig daisy-chain sequencer with per-board address decode
// Optional Ethernet board (device 2) is built only when AUTOCONFIG_ETH_EN is defined.
module minimig_autoconfig_chain #(
  parameter int ZII_ETH_MATCH_BITS = 8,
  parameter int ZIII_MATCH_BITS    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic        sel,
  input  logic [6:0]  address_in,
  input  logic [15:0] data_in,
  input  logic        hwr,
  input  logic        lwr,
  input  logic [2:0]  dev_present,
  input  logic [1:0]  zii_size,
  input  logic [15:0] dec_addr,
  output logic [1:0]  acdevice,
  output logic [2:0]  board_configured,
  output logic [2:0]  board_shutup,
  output logic [7:0]  zii_base,
  output logic [7:0]  eth_base,
  output logic [7:0]  ziii_base,
  output logic [2:0]  board_sel,
  output logic        chain_done
);

  typedef enum logic [1:0] {SEEK, OFFER, DONE} state_t;

  localparam logic [7:0] OFS_Z3_HI = 8'h44;
  localparam logic [7:0] OFS_HI    = 8'h48;
  localparam logic [7:0] OFS_LO    = 8'h4A;
  localparam logic [7:0] OFS_SHUT  = 8'h4C;
  localparam logic [7:0] ZIII_MASK = 8'(16'hFF00 >> ZIII_MATCH_BITS);

`ifdef AUTOCONFIG_ETH_EN
  localparam logic [2:0] CHAIN_MASK = 3'b111;
  localparam logic [7:0] ETH_MASK   = 8'(16'hFF00 >> ZII_ETH_MATCH_BITS);
  logic [3:0] stage_eth;
`else
  localparam logic [2:0] CHAIN_MASK = 3'b011;
`endif

  state_t     state;
  logic [2:0] configured;
  logic [2:0] shutup;
  logic [2:0] eligible;
  logic [3:0] stage_ram;
  logic [7:0] stage_z3;
  logic [7:0] offset;
  logic [7:0] zii_mask;
  logic       wr;
  logic       unused_bits;

  assign wr       = clk7_en & sel & (hwr | lwr);
  assign offset   = {address_in, 1'b0};
  assign eligible = dev_present & ~configured & ~shutup & CHAIN_MASK;

  assign board_configured = configured & CHAIN_MASK;
  assign board_shutup     = shutup & CHAIN_MASK;

  // ZIII A23..A16 are latched for completeness but never take part in decode.
  assign unused_bits = ^{data_in[11:0], stage_z3};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SEEK;
      acdevice   <= 2'd3;
      chain_done <= 1'b0;
      configured <= 3'b000;
      shutup     <= 3'b000;
      zii_base   <= 8'h00;
      ziii_base  <= 8'h00;
      stage_ram  <= 4'h0;
      stage_z3   <= 8'h00;
`ifdef AUTOCONFIG_ETH_EN
      eth_base   <= 8'h00;
      stage_eth  <= 4'h0;
`endif
    end else begin
      case (state)
        SEEK: begin
          if (eligible[0]) begin
            acdevice <= 2'd0;
            state    <= OFFER;
          end else if (eligible[1]) begin
            acdevice <= 2'd1;
            state    <= OFFER;
          end else if (eligible[2]) begin
            acdevice <= 2'd2;
            state    <= OFFER;
          end else begin
            acdevice   <= 2'd3;
            chain_done <= 1'b1;
            state      <= DONE;
          end
        end

        OFFER: begin
          if (wr) begin
            case (offset)
              OFS_LO: begin
                if (acdevice == 2'd0) stage_ram <= data_in[15:12];
`ifdef AUTOCONFIG_ETH_EN
                if (acdevice == 2'd2) stage_eth <= data_in[15:12];
`endif
              end
              OFS_HI: begin
                if (acdevice == 2'd0) begin
                  zii_base      <= {data_in[15:12], stage_ram};
                  configured[0] <= 1'b1;
                  state         <= SEEK;
                end
                if (acdevice == 2'd1) stage_z3 <= data_in[15:8];
`ifdef AUTOCONFIG_ETH_EN
                if (acdevice == 2'd2) begin
                  eth_base      <= {data_in[15:12], stage_eth};
                  configured[2] <= 1'b1;
                  state         <= SEEK;
                end
`endif
              end
              OFS_Z3_HI: begin
                // The ZIII base lives in the upper byte; a low-byte-only write carries none of it.
                if (acdevice == 2'd1 && hwr) begin
                  ziii_base     <= data_in[15:8];
                  configured[1] <= 1'b1;
                  state         <= SEEK;
                end
              end
              OFS_SHUT: begin
                shutup <= shutup | (3'b001 << acdevice);
                state  <= SEEK;
              end
              default: ;
            endcase
          end
        end

        DONE: state <= DONE;

        default: state <= SEEK;
      endcase
    end
  end

`ifndef AUTOCONFIG_ETH_EN
  assign eth_base = 8'h00;
`endif

  always_comb begin
    case (zii_size)
      2'b01:   zii_mask = 8'hE0;
      2'b10:   zii_mask = 8'hC0;
      2'b11:   zii_mask = 8'h80;
      default: zii_mask = 8'h00;
    endcase
    board_sel    = 3'b000;
    board_sel[0] = configured[0] && (zii_size != 2'b00) &&
                   (((dec_addr[7:0] ^ zii_base) & zii_mask) == 8'h00);
    board_sel[1] = configured[1] && (((dec_addr[15:8] ^ ziii_base) & ZIII_MASK) == 8'h00);
`ifdef AUTOCONFIG_ETH_EN
    board_sel[2] = configured[2] && (((dec_addr[7:0] ^ eth_base) & ETH_MASK) == 8'h00);
`endif
  end

endmodule

// File: tb/tb_minimig_autoconfig_chain.sv
// tb/tb_minimig_autoconfig_chain.sv - self-checking bench for the autoconfig chain sequencer
// Follows the AUTOCONFIG_ETH_EN build of the design.
module tb_minimig_autoconfig_chain;

  localparam int ETH_BITS = 8;
  localparam int Z3_BITS  = 8;
`ifdef AUTOCONFIG_ETH_EN
  localparam bit ETH_EN = 1'b1;
`else
  localparam bit ETH_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, clk7_en, sel, hwr, lwr;
  logic [6:0]  address_in;
  logic [15:0] data_in, dec_addr;
  logic [2:0]  dev_present;
  logic [1:0]  zii_size;
  logic [1:0]  acdevice;
  logic [2:0]  board_configured, board_shutup, board_sel;
  logic [7:0]  zii_base, eth_base, ziii_base;
  logic        chain_done;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the OS has done to the chain so far.
  logic [2:0] m_cfg, m_shut;
  logic [7:0] m_zbase, m_ebase, m_z3base;
  int         m_stage [3];
  int         m_cur;

  always #5 clk = ~clk;

  minimig_autoconfig_chain #(
    .ZII_ETH_MATCH_BITS(ETH_BITS),
    .ZIII_MATCH_BITS(Z3_BITS)
  ) dut (
    .clk(clk), .reset(reset), .clk7_en(clk7_en), .sel(sel),
    .address_in(address_in), .data_in(data_in), .hwr(hwr), .lwr(lwr),
    .dev_present(dev_present), .zii_size(zii_size), .dec_addr(dec_addr),
    .acdevice(acdevice), .board_configured(board_configured),
    .board_shutup(board_shutup), .zii_base(zii_base), .eth_base(eth_base),
    .ziii_base(ziii_base), .board_sel(board_sel), .chain_done(chain_done)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_bus();
    sel = 1'b0; hwr = 1'b0; lwr = 1'b0; clk7_en = 1'b1;
    address_in = 7'd0; data_in = 16'h0000;
  endtask

  task automatic do_write(input logic [7:0] off, input logic [15:0] data,
                          input logic h, input logic l, input logic en, input logic s);
    address_in = off[7:1]; data_in = data;
    hwr = h; lwr = l; clk7_en = en; sel = s;
    cyc(1);
    idle_bus();
  endtask

  task automatic wr(input logic [7:0] off, input logic [15:0] data);
    do_write(off, data, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic start_chain(input logic [2:0] dp);
    dev_present = dp;
    reset = 1'b1;
    idle_bus();
    cyc(1);
    reset = 1'b0;
    cyc(1);
  endtask

  function automatic int next_offer();
    for (int i = 0; i < 3; i++)
      if ((i < 2 || ETH_EN) && dev_present[i] && !m_cfg[i] && !m_shut[i]) return i;
    return 3;
  endfunction

  function automatic logic [2:0] model_sel(input logic [15:0] a);
    int win0, div1, div2;
    logic [2:0] r;
    win0 = 16 << zii_size;
    div1 = 1 << (8 - Z3_BITS);
    div2 = 1 << (8 - ETH_BITS);
    r[0] = m_cfg[0] && zii_size != 2'b00 && (int'(a[7:0]) / win0 == int'(m_zbase) / win0);
    r[1] = m_cfg[1] && (int'(a[15:8]) / div1 == int'(m_z3base) / div1);
    r[2] = ETH_EN && m_cfg[2] && (int'(a[7:0]) / div2 == int'(m_ebase) / div2);
    return r;
  endfunction

  task automatic model_reset();
    m_cfg = 3'b000; m_shut = 3'b000;
    m_zbase = 8'h00; m_ebase = 8'h00; m_z3base = 8'h00;
    for (int i = 0; i < 3; i++) m_stage[i] = 0;
  endtask

  task automatic test_reset();
    dev_present = 3'b011; zii_size = 2'b10; dec_addr = 16'h0000;
    reset = 1'b1; idle_bus();
    cyc(1);
    checks++; if (acdevice !== 2'd3) begin errors++; $display("FAIL reset_acdevice: got %0d expected 3", acdevice); end
    checks++; if (board_configured !== 3'b000 || board_shutup !== 3'b000) begin errors++; $display("FAIL reset_flags: got cfg %b shut %b expected 000 000", board_configured, board_shutup); end
    checks++; if ({zii_base, eth_base, ziii_base} !== 24'h0) begin errors++; $display("FAIL reset_bases: got %h expected 000000", {zii_base, eth_base, ziii_base}); end
    checks++; if (chain_done !== 1'b0 || board_sel !== 3'b000) begin errors++; $display("FAIL reset_done_sel: got done %b sel %b expected 0 000", chain_done, board_sel); end
    reset = 1'b0;
    cyc(1);
    checks++; if (acdevice !== 2'd0) begin errors++; $display("FAIL reset_first_offer: got %0d expected 0", acdevice); end
  endtask

  task automatic test_zii_ziii();
    wr(8'h48, 16'h2000);
    checks++; if (acdevice !== 2'd0) begin errors++; $display("FAIL zii_hold_acdevice: got %0d expected 0", acdevice); end
    cyc(1);
    checks++; if (acdevice !== 2'd1) begin errors++; $display("FAIL zii_next_offer: got %0d expected 1", acdevice); end
    checks++; if (board_configured !== 3'b001 || zii_base !== 8'h20) begin errors++; $display("FAIL zii_config: got cfg %b base %h expected 001 20", board_configured, zii_base); end
    dec_addr = 16'h0030; #1;
    checks++; if (board_sel !== 3'b001) begin errors++; $display("FAIL zii_sel_hit: got %b expected 001", board_sel); end
    dec_addr = 16'h0060; #1;
    checks++; if (board_sel !== 3'b000) begin errors++; $display("FAIL zii_sel_miss: got %b expected 000", board_sel); end
    wr(8'h48, 16'h0000);
    do_write(8'h44, 16'h4000, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1);
    checks++; if (acdevice !== 2'd1 || board_configured !== 3'b001) begin errors++; $display("FAIL ziii_lwr_ignored: got dev %0d cfg %b expected 1 001", acdevice, board_configured); end
    do_write(8'h44, 16'h4000, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1);
    checks++; if (ziii_base !== 8'h40 || board_configured !== 3'b011) begin errors++; $display("FAIL ziii_config: got base %h cfg %b expected 40 011", ziii_base, board_configured); end
    checks++; if (acdevice !== 2'd3 || chain_done !== 1'b1) begin errors++; $display("FAIL ziii_done: got dev %0d done %b expected 3 1", acdevice, chain_done); end
    dec_addr = 16'h40FF; #1;
    checks++; if (board_sel !== 3'b010) begin errors++; $display("FAIL ziii_sel: got %b expected 010", board_sel); end
    wr(8'h4C, 16'h0000);
    cyc(1);
    checks++; if (board_shutup !== 3'b000 || acdevice !== 2'd3) begin errors++; $display("FAIL done_ignores_writes: got shut %b dev %0d expected 000 3", board_shutup, acdevice); end
  endtask

  task automatic test_shutup();
    start_chain(3'b001);
    wr(8'h4C, 16'h0000);
    cyc(1);
    dec_addr = 16'($urandom); #1;
    checks++; if (board_shutup !== 3'b001 || board_configured !== 3'b000) begin errors++; $display("FAIL shutup_flags: got shut %b cfg %b expected 001 000", board_shutup, board_configured); end
    checks++; if (acdevice !== 2'd3 || chain_done !== 1'b1 || board_sel !== 3'b000) begin errors++; $display("FAIL shutup_done: got dev %0d done %b sel %b expected 3 1 000", acdevice, chain_done, board_sel); end
  endtask

  task automatic test_eth();
    zii_size = 2'b01;
    start_chain(3'b101);
    wr(8'h48, 16'h2000);
    cyc(1);
    checks++; if (acdevice !== (ETH_EN ? 2'd2 : 2'd3)) begin errors++; $display("FAIL eth_offer: got %0d expected %0d", acdevice, ETH_EN ? 2 : 3); end
    wr(8'h4A, 16'h8000);
    wr(8'h48, 16'hE000);
    cyc(1);
    checks++; if (eth_base !== (ETH_EN ? 8'hE8 : 8'h00)) begin errors++; $display("FAIL eth_base: got %h expected %h", eth_base, ETH_EN ? 8'hE8 : 8'h00); end
    checks++; if (board_configured !== (ETH_EN ? 3'b101 : 3'b001) || chain_done !== 1'b1) begin errors++; $display("FAIL eth_config: got cfg %b done %b", board_configured, chain_done); end
    for (int a = 0; a < 256; a++) begin
      dec_addr = 16'(a); #1;
      checks++;
      if (board_sel[2] !== (ETH_EN && a == 'hE8)) begin errors++; $display("FAIL eth_sel: addr %h got %b expected %b", a, board_sel[2], ETH_EN && a == 'hE8); end
    end
    zii_size = 2'b10;
  endtask

  task automatic test_gating();
    start_chain(3'b001);
    do_write(8'h48, 16'h2000, 1'b1, 1'b1, 1'b0, 1'b1);
    do_write(8'h48, 16'h2000, 1'b1, 1'b1, 1'b1, 1'b0);
    do_write(8'h48, 16'h2000, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(2);
    checks++; if (board_configured !== 3'b000 || zii_base !== 8'h00 || acdevice !== 2'd0) begin errors++; $display("FAIL gated_write: got cfg %b base %h dev %0d expected 000 00 0", board_configured, zii_base, acdevice); end
  endtask

  task automatic test_reset_mid_offer();
    start_chain(3'b001);
    wr(8'h4A, 16'hF000);
    reset = 1'b1;
    cyc(1);
    checks++; if (acdevice !== 2'd3 || board_configured !== 3'b000 || chain_done !== 1'b0) begin errors++; $display("FAIL midreset_state: got dev %0d cfg %b done %b expected 3 000 0", acdevice, board_configured, chain_done); end
    reset = 1'b0;
    cyc(1);
    checks++; if (acdevice !== 2'd0) begin errors++; $display("FAIL midreset_reoffer: got %0d expected 0", acdevice); end
    wr(8'h48, 16'h2000);
    checks++; if (zii_base !== 8'h20) begin errors++; $display("FAIL midreset_stale_stage: got %h expected 20", zii_base); end
  endtask

  task automatic test_empty_chain();
    dev_present = 3'b000;
    reset = 1'b1; idle_bus();
    cyc(1);
    checks++; if (chain_done !== 1'b0) begin errors++; $display("FAIL empty_in_reset: got done %b expected 0", chain_done); end
    reset = 1'b0;
    cyc(1);
    checks++; if (acdevice !== 2'd3 || chain_done !== 1'b1) begin errors++; $display("FAIL empty_chain: got dev %0d done %b expected 3 1", acdevice, chain_done); end
  endtask

  task automatic test_random();
    logic [7:0]  offs [5];
    logic [7:0]  off;
    logic [15:0] data, probe;
    logic        h, l, en, s;
    offs[0] = 8'h44; offs[1] = 8'h48; offs[2] = 8'h4A; offs[3] = 8'h4C; offs[4] = 8'h40;
    for (int it = 0; it < 40; it++) begin
      zii_size = 2'($urandom);
      start_chain(3'($urandom));
      model_reset();
      m_cur = next_offer();
      for (int op = 0; op < 12; op++) begin
        if ($urandom_range(0, 5) == 0) dev_present = 3'($urandom);
        off  = offs[$urandom_range(0, 4)];
        if ($urandom_range(0, 7) == 0) off = 8'($urandom_range(0, 127) * 2);
        data = 16'($urandom);
        h    = 1'($urandom); l = 1'($urandom);
        en   = ($urandom_range(0, 4) != 0);
        s    = ($urandom_range(0, 9) != 0);
        do_write(off, data, h, l, en, s);
        if (en && s && (h || l) && m_cur != 3) begin
          if (off == 8'h4A && m_cur != 1) m_stage[m_cur] = int'(data[15:12]);
          else if (off == 8'h48 && m_cur == 0) begin m_zbase = {data[15:12], 4'(m_stage[0])}; m_cfg[0] = 1'b1; m_cur = -1; end
          else if (off == 8'h48 && m_cur == 2) begin m_ebase = {data[15:12], 4'(m_stage[2])}; m_cfg[2] = 1'b1; m_cur = -1; end
          else if (off == 8'h44 && m_cur == 1 && h) begin m_z3base = data[15:8]; m_cfg[1] = 1'b1; m_cur = -1; end
          else if (off == 8'h4C) begin m_shut[m_cur] = 1'b1; m_cur = -1; end
        end
        cyc(1);
        if (m_cur < 0) m_cur = next_offer();
        checks++; if (int'(acdevice) != m_cur) begin errors++; $display("FAIL rnd_acdevice: it %0d op %0d got %0d expected %0d", it, op, acdevice, m_cur); end
        checks++; if (chain_done !== (m_cur == 3)) begin errors++; $display("FAIL rnd_done: it %0d op %0d got %b expected %b", it, op, chain_done, m_cur == 3); end
        checks++; if (board_configured !== m_cfg || board_shutup !== m_shut) begin errors++; $display("FAIL rnd_flags: it %0d got cfg %b shut %b expected %b %b", it, board_configured, board_shutup, m_cfg, m_shut); end
        checks++; if ({zii_base, eth_base, ziii_base} !== {m_zbase, m_ebase, m_z3base}) begin errors++; $display("FAIL rnd_bases: it %0d got %h expected %h", it, {zii_base, eth_base, ziii_base}, {m_zbase, m_ebase, m_z3base}); end
        for (int p = 0; p < 3; p++) begin
          case (p)
            0:       probe = 16'($urandom);
            1:       probe = {m_z3base, m_zbase ^ 8'($urandom_range(0, 127))};
            default: probe = {8'($urandom), m_ebase ^ 8'($urandom_range(0, 1))};
          endcase
          dec_addr = probe; #1;
          checks++; if (board_sel !== model_sel(probe)) begin errors++; $display("FAIL rnd_sel: addr %h size %0d got %b expected %b", probe, zii_size, board_sel, model_sel(probe)); end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; dev_present = 3'b000; zii_size = 2'b10; dec_addr = 16'h0000;
    idle_bus();
    test_reset();
    test_zii_ziii();
    test_shutup();
    test_eth();
    test_gating();
    test_reset_mid_offer();
    test_empty_chain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/minimig_autoconfig_chain.md
Name: minimig_autoconfig_chain

Overview:
- Sequences the Amiga autoconfig daisy chain at $E80000 across up to three boards: device 0 = Zorro II fast RAM, device 1 = Zorro III RAM, device 2 = Zorro II Ethernet.
- Tells the autoconfig ROM which board is currently offered (acdevice).
- Captures the base addresses the OS writes, and handles "shut up" requests.
- Produces per-board address-match selects used by the memory/peripheral decoders.

Parameters:
- ZII_ETH_MATCH_BITS, 8, number of A23..A16 bits compared for the Ethernet board (8 = 64 KB window).
- ZIII_MATCH_BITS, 8, number of A31..A24 bits compared for the ZIII board (8 = 16 MB window).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- clk7_en  in  1  7 MHz CPU-cycle enable; register writes are accepted only when high.
- sel  in  1  CPU access to autoconfig space $E8xxxx.
- address_in  in  7  CPU A7..A1 within autoconfig space.
- data_in  in  16  CPU write data.
- hwr  in  1  CPU high-byte write strobe.
- lwr  in  1  CPU low-byte write strobe.
- dev_present  in  3  board enables; bit0 = ZII RAM (fastram_config != 0), bit1 = ZIII, bit2 = ETH.
- zii_size  in  2  ZII RAM size: 01 = 2 MB, 10 = 4 MB, 11 = 8 MB.
- dec_addr  in  16  CPU A31..A16, used for decoding.
- acdevice  out  2  device index presented to the ROM; 3 = null board.
- board_configured  out  3  per-board configured flags.
- board_shutup  out  3  per-board shut-up flags.
- zii_base  out  8  ZII RAM base, A23..A16.
- eth_base  out  8  ETH base, A23..A16.
- ziii_base  out  8  ZIII base, A31..A24.
- board_sel  out  3  combinational decode hits, gated by board_configured.
- chain_done  out  1  no unconfigured board remains.

Behaviour:
- Reset (synchronous, clk edge with reset high):
  - State = SEEK.
  - acdevice = 3; board_configured, board_shutup, all bases, staging registers and chain_done = 0.
  - Reset mid-offer discards any partially staged base.
- State SEEK (1 cycle, independent of clk7_en):
  - Select the lowest index i where dev_present[i] & !board_configured[i] & !board_shutup[i].
  - If found: acdevice = i, go to OFFER.
  - Otherwise: acdevice = 3, chain_done = 1, go to DONE.
- State OFFER: a write is any clk7_en & sel & (hwr|lwr). Offsets are {address_in,1'b0}.
  - 0x4A, ZII device (0 or 2): stage_lo = data_in[15:12]. No state change.
  - 0x48, ZII device: base = {data_in[15:12], stage_lo}. Set board_configured[i]. Go to SEEK.
  - 0x48, ZIII device: stage_z3 = data_in[15:8]. No state change; A23..A16 are recorded only, not decoded.
  - 0x44, ZIII device, hwr only: ziii_base = data_in[15:8]. Set board_configured[1]. Go to SEEK. A 0x44 write with lwr only is ignored.
  - 0x4C, any device: set board_shutup[i]. Go to SEEK.
  - Writes at any other offset, and all reads: no effect.
  - A write while clk7_en = 0 is ignored.
  - acdevice holds its value throughout OFFER.
  - The next board is offered 2 clk cycles after the configuring write: 1 cycle to SEEK, 1 cycle to update acdevice.
- State DONE:
  - All writes are ignored.
  - acdevice = 3 until reset; the null board terminates the chain.
- Decode (combinational):
  - board_sel[0] = configured[0] & dec_addr[7:N] == zii_base[7:N], with N = 5/6/7 for 2/4/8 MB. zii_size = 00 forces 0.
  - board_sel[2] = configured[2] & top ZII_ETH_MATCH_BITS of dec_addr[7:0] match eth_base.
  - board_sel[1] = configured[1] & top ZIII_MATCH_BITS of dec_addr[15:8] match ziii_base.
- dev_present changes after reset take effect only at the next SEEK.
- Configured and shut-up flags are never cleared except by reset.

Optional Feature:
- AUTOCONFIG_ETH_EN defined: device 2 participates in the chain and decode exactly as described above.
- AUTOCONFIG_ETH_EN undefined:
  - dev_present[2] is ignored.
  - board_configured[2], board_shutup[2] and board_sel[2] are tied to 0; eth_base is tied to 0.
  - The ETH staging and eth_base registers are not synthesised.
  - After ZIII the chain goes straight to DONE.

Test Plan:
- dev_present = 011, zii_size = 10; release reset; write 0x48 data 0x2000 -> acdevice 0→1; board_configured = 001; zii_base = 0x20; dec_addr = 0x0030 gives board_sel[0] = 1; dec_addr = 0x0060 gives 0.
- Continue: write 0x48 data 0x0000, then 0x44 hwr data 0x4000 -> ziii_base = 0x40; board_configured = 011; chain_done = 1; acdevice = 3; dec_addr = 0x40FF gives board_sel[1] = 1.
- dev_present = 001; write 0x4C -> board_shutup = 001; board_configured = 000; acdevice = 3; chain_done = 1; board_sel = 000.
- AUTOCONFIG_ETH_EN defined, dev_present = 101: write 0x48 data 0x2000 to configure RAM, then write 0x4A data 0x8000 and 0x48 data 0xE000 -> eth_base = 0xE8; board_configured = 101; board_sel[2] = 1 only for dec_addr = 0x00E8.
- Write 0x48 with clk7_en = 0 -> no change. Assert reset for 1 cycle mid-OFFER after a 0x4A stage -> all outputs 0 and acdevice = 3 on that edge; the next cycle re-offers device 0, and the stale stage is not used.
- dev_present = 000 -> acdevice = 3 and chain_done = 1 one cycle after reset release.
